sketch_update_sched: RTL and testbench

Front-end scheduler for the banked count-min sketch: round-robin arbitration of NUM_REQ address-update requesters into the single sketch update port (fanned out to the hash lanes downstream). Enforces one idle cycle between issued updates, because the sketch's single-port read-modify-write RAM cannot take back-to-back updates. Sequences epoch boundaries: after EPOCH_LEN updates or a software clear, it drains the sketch pipeline and pulses the sketch's active-low query reset.

---
 rtl/sketch_update_sched_if.sv | 11 +
 rtl/sketch_update_sched.sv | 101 ++++++++++
 tb/tb_sketch_update_sched.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sketch_update_sched_if.sv
// sketch_update_sched_if: per-requester update handshake bundle
interface sketch_update_sched_if #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_SIZE = 22
);
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0][ADDR_SIZE-1:0] req_addr;
  logic [NUM_REQ-1:0]                req_ready;
  modport master (output req_valid, req_addr, input req_ready);
  modport slave (input req_valid, req_addr, output req_ready);
endinterface

// File: rtl/sketch_update_sched.sv
// sketch_update_sched: round-robin update scheduler with epoch drain/query-reset sequencing
module sketch_update_sched #(
  parameter int NUM_REQ       = 4,
  parameter int ADDR_SIZE     = 22,
  parameter int EPOCH_LEN     = 1024,
  parameter int DRAIN_CYCLES  = 4,
  parameter int QRST_CYCLES   = 2,
  parameter int EPOCH_ID_SIZE = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  sketch_update_sched_if.slave     req,
  input  logic                     clear_req,
  output logic                     issue_valid,
  output logic [ADDR_SIZE-1:0]     issue_addr,
  output logic                     query_rst_n,
  output logic                     epoch_done,
  output logic [EPOCH_ID_SIZE-1:0] epoch_id,
  output logic                     busy
);
  localparam int PW  = $clog2(NUM_REQ);
  localparam int CW  = $clog2(EPOCH_LEN + 1);
  localparam int PM  = DRAIN_CYCLES > QRST_CYCLES ? DRAIN_CYCLES : QRST_CYCLES;
  localparam int PHW = $clog2(PM);
  typedef enum logic [1:0] {RUN, DRAIN, QRST} state_t;
  state_t         state;
  logic [PW-1:0]  ptr, gnt;
  logic [CW-1:0]  cnt;
  logic [PHW-1:0] phase;
  logic           clear_pending, found, can_accept, acc;
  int             idx;
  assign can_accept = (state == RUN) && !issue_valid && !clear_pending;
  assign acc = can_accept && found;
  assign req.req_ready = acc ? NUM_REQ'(1) << gnt : '0;
  // first valid requester at or after the round-robin pointer, wrapping
  always_comb begin
    gnt = '0;
    found = 1'b0;
    idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req.req_valid[idx]) begin
        gnt = PW'(idx);
        found = 1'b1;
      end
    end
  end
  // issue register, arbitration pointer and epoch-close state machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      ptr <= '0;
      cnt <= '0;
      phase <= '0;
      clear_pending <= 1'b0;
      issue_valid <= 1'b0;
      issue_addr <= '0;
      query_rst_n <= 1'b1;
      epoch_done <= 1'b0;
      epoch_id <= '0;
      busy <= 1'b0;
    end else begin
      issue_valid <= acc;
      epoch_done <= 1'b0;
      if (acc) begin
        issue_addr <= req.req_addr[gnt];
        ptr <= (gnt == PW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
      end
      case (state)
        RUN: begin
          if (acc) cnt <= cnt + 1'b1;
          if (clear_pending || (acc && cnt == CW'(EPOCH_LEN - 1))) begin
            state <= DRAIN;
            busy <= 1'b1;
            phase <= '0;
            clear_pending <= 1'b0;
          end else if (clear_req) clear_pending <= 1'b1;
        end
        DRAIN: begin
          phase <= phase + 1'b1;
          if (phase == PHW'(DRAIN_CYCLES - 1)) begin
            state <= QRST;
            phase <= '0;
            query_rst_n <= 1'b0;
          end
        end
        default: begin
          phase <= phase + 1'b1;
          if (phase == PHW'(QRST_CYCLES - 1)) begin
            state <= RUN;
            busy <= 1'b0;
            query_rst_n <= 1'b1;
            epoch_done <= 1'b1;
            epoch_id <= epoch_id + 1'b1;
            cnt <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sketch_update_sched.sv
// tb_sketch_update_sched: directed table and sequence checks for the update scheduler
module tb_sketch_update_sched;
  localparam logic [21:0] A = 22'h12345;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_req = 1'b0;
  logic        issue_valid, query_rst_n, epoch_done, busy, prev_iv;
  logic [21:0] issue_addr;
  logic [15:0] epoch_id;
  int          n_cmp = 0;
  int          n_bad = 0;
  sketch_update_sched_if #(.NUM_REQ(4), .ADDR_SIZE(22)) rif ();
  sketch_update_sched #(
    .NUM_REQ(4), .ADDR_SIZE(22), .EPOCH_LEN(4),
    .DRAIN_CYCLES(4), .QRST_CYCLES(2), .EPOCH_ID_SIZE(16)
  ) dut (
    .clk(clk), .rst(rst), .req(rif.slave), .clear_req(clear_req),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .query_rst_n(query_rst_n),
    .epoch_done(epoch_done), .epoch_id(epoch_id), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  v;
    logic        c;
    logic [3:0]  rdy;
    logic        iv;
    logic [21:0] addr;
    logic        qn;
    logic        done;
    logic        bsy;
    logic [15:0] eid;
  } vec_t;
  vec_t tv[15];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic set(input logic [3:0] v, input logic c);
    rif.req_valid = v;
    clear_req = c;
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    set(4'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask
  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      nxt();
      seen = epoch_done;
    end
    chk(name, 32'(seen), 1);
  endtask
  // protocol invariants sampled mid-cycle
  always @(negedge clk) begin
    if (rst) prev_iv = 1'b0;
    else begin
      chk("b2b_issue", 32'(issue_valid && prev_iv), 0);
      chk("issue_in_qrst", 32'(issue_valid && !query_rst_n), 0);
      prev_iv = issue_valid;
    end
  end
  initial begin
    rif.req_addr[0] = A;
    rif.req_addr[1] = 22'h00101;
    rif.req_addr[2] = 22'h00202;
    rif.req_addr[3] = 22'h00303;
    tv[0]  = '{4'b0001, 1'b0, 4'b0001, 1'b0, 22'h0, 1'b1, 1'b0, 1'b0, 16'd0};
    tv[1]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, A,     1'b1, 1'b0, 1'b0, 16'd0};
    tv[2]  = '{4'b0001, 1'b0, 4'b0001, 1'b0, A,     1'b1, 1'b0, 1'b0, 16'd0};
    tv[3]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, A,     1'b1, 1'b0, 1'b0, 16'd0};
    tv[4]  = '{4'b0001, 1'b0, 4'b0001, 1'b0, A,     1'b1, 1'b0, 1'b0, 16'd0};
    tv[5]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, A,     1'b1, 1'b0, 1'b0, 16'd0};
    tv[6]  = '{4'b0001, 1'b0, 4'b0001, 1'b0, A,     1'b1, 1'b0, 1'b0, 16'd0};
    tv[7]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, A,     1'b1, 1'b0, 1'b1, 16'd0};
    tv[8]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, A,     1'b1, 1'b0, 1'b1, 16'd0};
    tv[9]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, A,     1'b1, 1'b0, 1'b1, 16'd0};
    tv[10] = '{4'b0001, 1'b0, 4'b0000, 1'b0, A,     1'b1, 1'b0, 1'b1, 16'd0};
    tv[11] = '{4'b0001, 1'b0, 4'b0000, 1'b0, A,     1'b0, 1'b0, 1'b1, 16'd0};
    tv[12] = '{4'b0001, 1'b0, 4'b0000, 1'b0, A,     1'b0, 1'b0, 1'b1, 16'd0};
    tv[13] = '{4'b0001, 1'b0, 4'b0001, 1'b0, A,     1'b1, 1'b1, 1'b0, 16'd1};
    tv[14] = '{4'b0001, 1'b0, 4'b0000, 1'b1, A,     1'b1, 1'b0, 1'b0, 16'd1};
    do_reset();
    // single requester, full epoch of 4 updates
    for (int k = 0; k < 15; k++) begin
      if (k > 0) nxt();
      set(tv[k].v, tv[k].c);
      chk($sformatf("v%0d.ready", k), 32'(rif.req_ready), 32'(tv[k].rdy));
      chk($sformatf("v%0d.issue_valid", k), 32'(issue_valid), 32'(tv[k].iv));
      chk($sformatf("v%0d.issue_addr", k), 32'(issue_addr), 32'(tv[k].addr));
      chk($sformatf("v%0d.query_rst_n", k), 32'(query_rst_n), 32'(tv[k].qn));
      chk($sformatf("v%0d.epoch_done", k), 32'(epoch_done), 32'(tv[k].done));
      chk($sformatf("v%0d.busy", k), 32'(busy), 32'(tv[k].bsy));
      chk($sformatf("v%0d.epoch_id", k), 32'(epoch_id), 32'(tv[k].eid));
    end
    // all requesters valid: strict rotation, alternate-cycle grants
    do_reset();
    set(4'b1111, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr%0d.ready", k), 32'(rif.req_ready), 32'(4'b0001 << k));
      nxt();
      chk($sformatf("rr%0d.gap", k), 32'(rif.req_ready), 0);
      chk($sformatf("rr%0d.addr", k), 32'(issue_addr), 32'(rif.req_addr[k]));
      nxt();
    end
    wait_done("rr.epoch_done");
    chk("rr.wrap_ready", 32'(rif.req_ready), 32'(4'b0001));
    // sparse requesters 1 and 3 with pointer parked at 2
    do_reset();
    set(4'b0010, 1'b0);
    chk("sp.first", 32'(rif.req_ready), 32'(4'b0010));
    nxt();
    set(4'b1010, 1'b0);
    nxt();
    chk("sp.g3a", 32'(rif.req_ready), 32'(4'b1000));
    nxt();
    nxt();
    chk("sp.g1", 32'(rif.req_ready), 32'(4'b0010));
    nxt();
    nxt();
    chk("sp.g3b", 32'(rif.req_ready), 32'(4'b1000));
    // software clear at count 2, second clear absorbed during QRST
    do_reset();
    set(4'b0001, 1'b0);
    nxt();
    nxt();
    chk("cl.acc2", 32'(rif.req_ready), 32'(4'b0001));
    nxt();
    set(4'b0000, 1'b1);
    nxt();
    set(4'b0001, 1'b0);
    chk("cl.pending_block", 32'(rif.req_ready), 0);
    chk("cl.pending_busy", 32'(busy), 0);
    nxt();
    chk("cl.drain_busy", 32'(busy), 1);
    repeat (4) nxt();
    set(4'b0001, 1'b1);
    chk("cl.qrst_low", 32'(query_rst_n), 0);
    nxt();
    set(4'b0001, 1'b0);
    nxt();
    chk("cl.done", 32'(epoch_done), 1);
    chk("cl.eid", 32'(epoch_id), 1);
    chk("cl.ready", 32'(rif.req_ready), 32'(4'b0001));
    for (int k = 12; k < 18; k++) begin
      nxt();
      chk($sformatf("cl.run%0d", k), 32'(busy), 0);
    end
    nxt();
    chk("cl.count_restart_close", 32'(busy), 1);
    // clear coincident with the epoch-closing accept
    do_reset();
    set(4'b0001, 1'b0);
    repeat (6) nxt();
    set(4'b0001, 1'b1);
    chk("ce.acc4", 32'(rif.req_ready), 32'(4'b0001));
    nxt();
    set(4'b0000, 1'b0);
    chk("ce.busy", 32'(busy), 1);
    wait_done("ce.epoch_done");
    chk("ce.eid", 32'(epoch_id), 1);
    for (int k = 0; k < 6; k++) begin
      nxt();
      chk($sformatf("ce.idle%0d", k), 32'(busy), 0);
    end
    chk("ce.eid_hold", 32'(epoch_id), 1);
    // async reset in the middle of QRST
    set(4'b0001, 1'b0);
    begin
      bit low = 0;
      for (int i = 0; i < 40 && !low; i++) begin
        nxt();
        low = !query_rst_n;
      end
      chk("rs.reach_qrst", 32'(low), 1);
    end
    rst = 1'b1;
    #1;
    chk("rs.qrn", 32'(query_rst_n), 1);
    chk("rs.busy", 32'(busy), 0);
    chk("rs.eid", 32'(epoch_id), 0);
    chk("rs.iv", 32'(issue_valid), 0);
    chk("rs.done", 32'(epoch_done), 0);
    nxt();
    rst = 1'b0;
    #1;
    chk("rs.first_ready", 32'(rif.req_ready), 32'(4'b0001));
    nxt();
    chk("rs.first_issue", 32'(issue_valid), 1);
    chk("rs.first_addr", 32'(issue_addr), 32'(A));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
